// File: rtl/tmu2_burst_reader_pkg.sv
// Shared TMU2 constants: burst FSM encodings, line geometry, word-lane selection.
// Word 0 of a line sits in the most significant 16 bits, as in the write combiner.
package tmu2_burst_reader_pkg;

  typedef enum logic [1:0] {
    RUNNING = 2'd0,
    FETCH   = 2'd1,
    WAIT    = 2'd2
  } state_t;

  localparam int WORDS_PER_LINE = 16;
  localparam int WORD_IDX_W     = 4;
  localparam int LINE_W         = WORDS_PER_LINE * 16;

  function automatic logic [15:0] line_word(input logic [LINE_W-1:0] line,
                                            input logic [WORD_IDX_W-1:0] idx);
    logic [7:0] lsb;
    lsb = {4'd15 - idx, 4'd0};
    return line[lsb +: 16];
  endfunction

endpackage

// File: rtl/tmu2_burst_reader_if.sv
// Texel pipeline and FML line-fetch signals of the burst reader.
// master is the reader's view; slave is the surrounding pipeline/fetcher.
interface tmu2_burst_reader_if #(parameter int fml_depth = 26);

  logic                 pipe_stb_i;
  logic                 pipe_ack_o;
  logic [fml_depth-2:0] dadr;
  logic                 pipe_stb_o;
  logic                 pipe_ack_i;
  logic [15:0]          color;
  logic                 fetch_stb_o;
  logic                 fetch_ack_i;
  logic [fml_depth-6:0] fetch_addr;
  logic                 line_stb_i;
  logic [255:0]         fetch_dat_i;

  modport master (
    input  pipe_stb_i, dadr, pipe_ack_i, fetch_ack_i, line_stb_i, fetch_dat_i,
    output pipe_ack_o, pipe_stb_o, color, fetch_stb_o, fetch_addr
  );

  modport slave (
    output pipe_stb_i, dadr, pipe_ack_i, fetch_ack_i, line_stb_i, fetch_dat_i,
    input  pipe_ack_o, pipe_stb_o, color, fetch_stb_o, fetch_addr
  );

endinterface

// File: rtl/tmu2_wordsel.sv
// Combinational 256-to-16 word mux indexed by the in-line word number.
module tmu2_wordsel
  import tmu2_burst_reader_pkg::*;
(
  input  logic [LINE_W-1:0]     line,
  input  logic [WORD_IDX_W-1:0] idx,
  output logic [15:0]           word
);

  assign word = line_word(line, idx);

endmodule

// File: rtl/tmu2_burst_reader.sv
// Single-line read cache in front of the FML line fetcher: hits are served from
// the held line, misses fetch and install a new line before answering.
module tmu2_burst_reader
  import tmu2_burst_reader_pkg::*;
#(
  parameter int fml_depth = 26
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                flush,
  output logic                busy,
  tmu2_burst_reader_if.master bus
);

  localparam int TAG_W = fml_depth - 5;

  state_t               state_r;
  state_t               state_next_s;
  logic                 valid_r;
  logic [TAG_W-1:0]     tag_r;
  logic [LINE_W-1:0]    line_r;
  logic [fml_depth-2:0] dadr_r;
  logic [15:0]          color_r;
  logic                 pipe_stb_r;

  logic                 pipe_ack_s;
  logic                 hit_s;
  logic                 accept_s;
  logic                 arrive_s;
  logic [15:0]          hit_word_s;
  logic [15:0]          arrive_word_s;

  assign hit_s      = valid_r & (bus.dadr[fml_depth-2:WORD_IDX_W] == tag_r);
  assign pipe_ack_s = (state_r == RUNNING) & ~flush & (~pipe_stb_r | bus.pipe_ack_i);
  assign accept_s   = bus.pipe_stb_i & pipe_ack_s;
  // A line pulse coinciding with the fetch acknowledge counts as the WAIT arrival.
  assign arrive_s   = bus.line_stb_i &
                      ((state_r == WAIT) | ((state_r == FETCH) & bus.fetch_ack_i));

  assign bus.pipe_ack_o  = pipe_ack_s;
  assign bus.pipe_stb_o  = pipe_stb_r;
  assign bus.color       = color_r;
  assign bus.fetch_stb_o = (state_r == FETCH);
  assign bus.fetch_addr  = dadr_r[fml_depth-2:WORD_IDX_W];
  assign busy            = (state_r != RUNNING) | pipe_stb_r;

  tmu2_wordsel u_hit_sel (
    .line (line_r),
    .idx  (bus.dadr[WORD_IDX_W-1:0]),
    .word (hit_word_s)
  );

  tmu2_wordsel u_arrive_sel (
    .line (bus.fetch_dat_i),
    .idx  (dadr_r[WORD_IDX_W-1:0]),
    .word (arrive_word_s)
  );

  // Next-state decode of the miss/fetch sequencer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      RUNNING: begin
        if (accept_s & ~hit_s) state_next_s = FETCH;
        else                   state_next_s = RUNNING;
      end
      FETCH: begin
        if (arrive_s)             state_next_s = RUNNING;
        else if (bus.fetch_ack_i) state_next_s = WAIT;
        else                      state_next_s = FETCH;
      end
      WAIT: begin
        if (arrive_s) state_next_s = RUNNING;
        else          state_next_s = WAIT;
      end
      default: state_next_s = RUNNING;
    endcase
  end

  // State register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state_r <= RUNNING;
    else         state_r <= state_next_s;
  end

  // Held line, tag, valid bit and the address of the missing request.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      valid_r <= 1'b0;
      tag_r   <= '0;
      line_r  <= '0;
      dadr_r  <= '0;
    end else begin
      if (arrive_s) begin
        line_r  <= bus.fetch_dat_i;
        tag_r   <= dadr_r[fml_depth-2:WORD_IDX_W];
        valid_r <= 1'b1;
      end else if ((state_r == RUNNING) & flush) begin
        valid_r <= 1'b0;
      end
      if (accept_s & ~hit_s) dadr_r <= bus.dadr;
    end
  end

  // Output word register; the RUNNING ack rule guarantees the slot is free on arrival.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      color_r    <= 16'd0;
      pipe_stb_r <= 1'b0;
    end else if (accept_s & hit_s) begin
      color_r    <= hit_word_s;
      pipe_stb_r <= 1'b1;
    end else if (arrive_s) begin
      color_r    <= arrive_word_s;
      pipe_stb_r <= 1'b1;
    end else if (bus.pipe_ack_i) begin
      pipe_stb_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tmu2_burst_reader.sv
// Directed bench for tmu2_burst_reader: miss/fill, streaming hits, back-pressure,
// flush during a fetch, coincident ack/line, and reset in the middle of a fetch.
module tb_tmu2_burst_reader;

  logic sys_clk = 1'b0;
  logic sys_rst;
  logic flush;
  logic busy;
  int   checks   = 0;
  int   failures = 0;

  tmu2_burst_reader_if #(.fml_depth(26)) bus ();

  tmu2_burst_reader #(.fml_depth(26)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .flush   (flush),
    .busy    (busy),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Line whose word k (word 0 in the top 16 bits) holds base+k.
  function automatic logic [255:0] mk_line(input logic [15:0] base);
    logic [255:0] l;
    l = '0;
    for (int k = 0; k < 16; k++) l[255-16*k -: 16] = base + 16'(k);
    return l;
  endfunction

  initial begin
    sys_rst         = 1'b1;
    flush           = 1'b0;
    bus.pipe_stb_i  = 1'b0;
    bus.dadr        = '0;
    bus.pipe_ack_i  = 1'b0;
    bus.fetch_ack_i = 1'b0;
    bus.line_stb_i  = 1'b0;
    bus.fetch_dat_i = '0;
    tick();
    tick();
    sys_rst = 1'b0;
    #1;
    chk("rst_pipe_stb", 32'(bus.pipe_stb_o), 32'd0);
    chk("rst_fetch_stb", 32'(bus.fetch_stb_o), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pipe_ack", 32'(bus.pipe_ack_o), 32'd1);
    chk("rst_color", 32'(bus.color), 32'd0);

    // Miss on line 1
    bus.dadr = 25'h10;
    bus.pipe_stb_i = 1'b1;
    #1;
    chk("miss_ack", 32'(bus.pipe_ack_o), 32'd1);
    tick();
    bus.pipe_stb_i = 1'b0;
    #1;
    chk("miss_fetch_stb", 32'(bus.fetch_stb_o), 32'd1);
    chk("miss_fetch_addr", 32'(bus.fetch_addr), 32'h1);
    chk("miss_busy", 32'(busy), 32'd1);
    chk("miss_ack_blocked", 32'(bus.pipe_ack_o), 32'd0);
    tick();
    chk("fetch_stb_hold", 32'(bus.fetch_stb_o), 32'd1);
    chk("fetch_addr_hold", 32'(bus.fetch_addr), 32'h1);
    bus.fetch_ack_i = 1'b1;
    tick();
    bus.fetch_ack_i = 1'b0;
    #1;
    chk("wait_fetch_stb", 32'(bus.fetch_stb_o), 32'd0);
    chk("wait_busy", 32'(busy), 32'd1);
    tick();
    tick();
    bus.line_stb_i = 1'b1;
    bus.fetch_dat_i = mk_line(16'hA5A5);
    #1;
    chk("pre_line_pipe_stb", 32'(bus.pipe_stb_o), 32'd0);
    tick();
    bus.line_stb_i = 1'b0;
    #1;
    chk("fill_pipe_stb", 32'(bus.pipe_stb_o), 32'd1);
    chk("fill_color", 32'(bus.color), 32'hA5A5);

    // Streaming hits on the rest of line 1
    for (int k = 1; k < 16; k++) begin
      bus.pipe_stb_i = 1'b1;
      bus.pipe_ack_i = 1'b1;
      bus.dadr = 25'h10 + 25'(k);
      #1;
      chk("stream_ack", 32'(bus.pipe_ack_o), 32'd1);
      chk("stream_no_fetch", 32'(bus.fetch_stb_o), 32'd0);
      tick();
      chk("stream_stb", 32'(bus.pipe_stb_o), 32'd1);
      chk("stream_color", 32'(bus.color), 32'hA5A5 + 32'(k));
    end
    bus.pipe_stb_i = 1'b0;
    tick();
    chk("stream_drain_stb", 32'(bus.pipe_stb_o), 32'd0);
    chk("stream_drain_busy", 32'(busy), 32'd0);

    // Back-pressure on a held hit word
    bus.pipe_ack_i = 1'b0;
    bus.dadr = 25'h13;
    bus.pipe_stb_i = 1'b1;
    #1;
    chk("bp_first_ack", 32'(bus.pipe_ack_o), 32'd1);
    tick();
    bus.dadr = 25'h14;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("bp_ack_low", 32'(bus.pipe_ack_o), 32'd0);
      chk("bp_stb_hold", 32'(bus.pipe_stb_o), 32'd1);
      chk("bp_color_hold", 32'(bus.color), 32'hA5A8);
      tick();
    end
    bus.pipe_ack_i = 1'b1;
    #1;
    chk("bp_release_ack", 32'(bus.pipe_ack_o), 32'd1);
    tick();
    bus.pipe_stb_i = 1'b0;
    chk("bp_next_color", 32'(bus.color), 32'hA5A9);
    chk("bp_next_stb", 32'(bus.pipe_stb_o), 32'd1);
    tick();
    chk("bp_no_dup", 32'(bus.pipe_stb_o), 32'd0);

    // Flush raised while waiting for line 2
    bus.dadr = 25'h25;
    bus.pipe_stb_i = 1'b1;
    #1;
    chk("fl_miss_ack", 32'(bus.pipe_ack_o), 32'd1);
    tick();
    bus.pipe_stb_i = 1'b0;
    #1;
    chk("fl_fetch_addr", 32'(bus.fetch_addr), 32'h2);
    bus.fetch_ack_i = 1'b1;
    tick();
    bus.fetch_ack_i = 1'b0;
    flush = 1'b1;
    #1;
    chk("fl_wait_busy", 32'(busy), 32'd1);
    chk("fl_wait_ack", 32'(bus.pipe_ack_o), 32'd0);
    bus.line_stb_i = 1'b1;
    bus.fetch_dat_i = mk_line(16'h1200);
    tick();
    bus.line_stb_i = 1'b0;
    #1;
    chk("fl_fill_stb", 32'(bus.pipe_stb_o), 32'd1);
    chk("fl_fill_color", 32'(bus.color), 32'h1205);
    chk("fl_ack_blocked", 32'(bus.pipe_ack_o), 32'd0);
    tick();
    chk("fl_stb_clear", 32'(bus.pipe_stb_o), 32'd0);
    chk("fl_busy_low", 32'(busy), 32'd0);
    flush = 1'b0;
    bus.dadr = 25'h25;
    bus.pipe_stb_i = 1'b1;
    #1;
    chk("fl_req_ack", 32'(bus.pipe_ack_o), 32'd1);
    tick();
    bus.pipe_stb_i = 1'b0;
    #1;
    chk("fl_refetch_stb", 32'(bus.fetch_stb_o), 32'd1);
    chk("fl_refetch_addr", 32'(bus.fetch_addr), 32'h2);

    // Fetch acknowledge and line pulse in the same cycle
    bus.fetch_ack_i = 1'b1;
    bus.line_stb_i = 1'b1;
    bus.fetch_dat_i = mk_line(16'h1200);
    tick();
    bus.fetch_ack_i = 1'b0;
    bus.line_stb_i = 1'b0;
    #1;
    chk("co_stb", 32'(bus.pipe_stb_o), 32'd1);
    chk("co_color", 32'(bus.color), 32'h1205);
    chk("co_fetch_stb", 32'(bus.fetch_stb_o), 32'd0);
    bus.dadr = 25'h26;
    bus.pipe_stb_i = 1'b1;
    #1;
    chk("co_running_ack", 32'(bus.pipe_ack_o), 32'd1);
    tick();
    bus.pipe_stb_i = 1'b0;
    #1;
    chk("co_hit_color", 32'(bus.color), 32'h1206);
    chk("co_hit_stb", 32'(bus.pipe_stb_o), 32'd1);
    chk("co_hit_no_fetch", 32'(bus.fetch_stb_o), 32'd0);
    tick();
    chk("co_drain_busy", 32'(busy), 32'd0);

    // Reset while waiting for line 3
    bus.dadr = 25'h31;
    bus.pipe_stb_i = 1'b1;
    tick();
    bus.pipe_stb_i = 1'b0;
    bus.fetch_ack_i = 1'b1;
    tick();
    bus.fetch_ack_i = 1'b0;
    #1;
    chk("rw_wait_busy", 32'(busy), 32'd1);
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    #1;
    chk("rw_pipe_stb", 32'(bus.pipe_stb_o), 32'd0);
    chk("rw_fetch_stb", 32'(bus.fetch_stb_o), 32'd0);
    chk("rw_busy", 32'(busy), 32'd0);
    chk("rw_color", 32'(bus.color), 32'd0);
    bus.line_stb_i = 1'b1;
    bus.fetch_dat_i = mk_line(16'h3300);
    tick();
    bus.line_stb_i = 1'b0;
    #1;
    chk("rw_late_line_stb", 32'(bus.pipe_stb_o), 32'd0);
    chk("rw_late_line_busy", 32'(busy), 32'd0);
    bus.dadr = 25'h26;
    bus.pipe_stb_i = 1'b1;
    tick();
    bus.pipe_stb_i = 1'b0;
    #1;
    chk("rw_miss_fetch_stb", 32'(bus.fetch_stb_o), 32'd1);
    chk("rw_miss_fetch_addr", 32'(bus.fetch_addr), 32'h2);
    chk("rw_miss_no_word", 32'(bus.pipe_stb_o), 32'd0);

    sys_rst = 1'b1;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tmu2_burst_reader.md
# tmu2_burst_reader

Read-side counterpart of the TMU2 burst write combiner. Accepts 16-bit word read requests (16-bit-word addresses) from the texel pipeline and holds one 256-bit line with its tag. Hits are answered from that line. Misses issue a line fetch to the FML read master, install the returned line, then answer. Sits between the TMU2 address generator and the FML line fetcher, with the same burst addressing and word order as the write combiner.

## Interface
Parameters:
- fml_depth, 26, FML address width in bytes; word address is fml_depth-1 bits, line address fml_depth-5 bits.

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- flush  in  1  level; invalidates held line (see Operation).
- busy  out  1  high while a fetch is outstanding or an output word is pending.
- pipe_stb_i  in  1  upstream request valid.
- pipe_ack_o  out  1  upstream request accepted.
- dadr  in  fml_depth-1  requested word address, in 16-bit words.
- pipe_stb_o  out  1  output word valid.
- pipe_ack_i  in  1  downstream accepts output word.
- color  out  16  returned word.
- fetch_stb_o  out  1  line fetch request.
- fetch_ack_i  in  1  fetcher accepts request.
- fetch_addr  out  fml_depth-5  requested line, in 256-bit words.
- line_stb_i  in  1  one-cycle pulse: fetch_dat_i valid.
- fetch_dat_i  in  256  returned line.

## Operation
- Internal state: valid bit, tag (fml_depth-5), line register (256), captured dadr_r, output register (color, pipe_stb_o).
- hit = valid & (dadr[fml_depth-2:4] == tag).
- Word select: dadr[3:0]=0 → line[255:240], 1 → [239:224], … 15 → [15:0]. This is the same order as the write combiner's burst_do/burst_sel.
- FSM states: RUNNING, FETCH, WAIT.
- RUNNING:
  - pipe_ack_o = ~flush & (~pipe_stb_o | pipe_ack_i).
  - flush high: clear valid; no request is accepted.
  - Accepted request on a hit: load selected word into color; set pipe_stb_o.
  - Accepted request on a miss: capture dadr_r; go to FETCH.
- FETCH:
  - fetch_stb_o=1; fetch_addr=dadr_r[fml_depth-2:4].
  - On fetch_ack_i, go to WAIT.
  - If line_stb_i coincides with fetch_ack_i, treat as WAIT arrival.
- WAIT:
  - On line_stb_i: line←fetch_dat_i, tag←dadr_r line field, valid←1.
  - In the same edge, load color from fetch_dat_i using dadr_r[3:0] and set pipe_stb_o. Return to RUNNING.
- Output slot is free whenever a line arrives, guaranteed by the RUNNING ack condition; no overwrite check is needed.
- Output holding: pipe_stb_o and color hold until pipe_ack_i; then pipe_stb_o clears unless reloaded in the same edge.
- busy = (state != RUNNING) | pipe_stb_o.
- flush is honoured only in RUNNING. A line installed by an in-flight fetch becomes valid. The driver holds flush until busy is low; one RUNNING cycle with flush high then invalidates.
- line_stb_i outside FETCH/WAIT is ignored.

## Timing
- Reset values: state RUNNING, valid 0, pipe_stb_o 0, fetch_stb_o 0, busy 0, pipe_ack_o 1 (if flush low), color 0.
- Hit latency: accepted at edge N, pipe_stb_o high in cycle N+1. Back-to-back hits sustain 1 word/cycle when pipe_ack_i is held high.
- Miss: accepted at edge N; fetch_stb_o high from cycle N+1 until fetch_ack_i. pipe_stb_o rises the cycle after line_stb_i.
- pipe_ack_o, fetch_stb_o and busy are combinational from registered state plus flush/pipe_ack_i. color and pipe_stb_o are registered.
- fetch_addr is stable while fetch_stb_o is high.
- Reset mid-fetch: all state returns to reset values at the next edge. The fetcher shares sys_rst.

## Structure
- Shared TMU2 constants header holds:
  - FSM state encodings: RUNNING=2'd0, FETCH=2'd1, WAIT=2'd2.
  - Words per line (16) and word-index width (4), shared with the write combiner.
- One natural sub-module: tmu2_wordsel, a combinational 256→16 mux indexed by a 4-bit word index. It is instantiated twice: once on the line register for hits, once on fetch_dat_i for arrivals.
- Expected RTL: ~150–250 lines.

## Test plan
- Reset then dadr=0x000010 → fetch_stb_o with fetch_addr=0x000001. fetch_ack_i, then line_stb_i 3 cycles later with word0=0xA5A5 → color=0xA5A5 one cycle after line_stb_i.
- Following requests dadr=0x000011..0x00001F with pipe_ack_i held high → 15 consecutive words, 1/cycle, no fetch_stb_o.
- Hit while pipe_ack_i low for 4 cycles → pipe_ack_o low, color and pipe_stb_o held stable, no request lost or duplicated.
- flush during WAIT → busy stays high; line installs and the word is delivered. Flush held until busy low → valid cleared; next dadr=0x000010 refetches line 0x000001.
- fetch_ack_i and line_stb_i in the same cycle → pipe_stb_o next cycle with the correct word; state returns to RUNNING.
- sys_rst asserted in WAIT → next cycle pipe_stb_o=0, fetch_stb_o=0, busy=0. A late line_stb_i is ignored, and a subsequent hit-candidate request misses.
